// File: rtl/fir_channel_arbiter.sv
// Frame-level round-robin arbiter that time-shares one lowpass_fir among NCH
// AXI-Stream sources and demuxes the FIR output by tuser. Optional watchdog: FIR_ARB_WDOG_EN.
module fir_channel_arbiter #(
  parameter int NCH     = 4,
  parameter int CW      = 2,
  parameter int DW      = 24,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH*DW-1:0] s_tdata,
  input  logic [NCH-1:0]    s_tvalid,
  output logic [NCH-1:0]    s_tready,
  input  logic [NCH-1:0]    s_tlast,
  output logic [DW-1:0]     f_s_tdata,
  output logic              f_s_tvalid,
  input  logic              f_s_tready,
  output logic [CW-1:0]     f_s_tuser,
  output logic              f_s_tlast,
  input  logic [DW-1:0]     f_m_tdata,
  input  logic              f_m_tvalid,
  output logic              f_m_tready,
  input  logic [CW-1:0]     f_m_tuser,
  input  logic              f_m_tlast,
  output logic [DW-1:0]     m_tdata,
  output logic [NCH-1:0]    m_tvalid,
  input  logic [NCH-1:0]    m_tready,
  output logic              m_tlast,
  output logic [CW-1:0]     grant_ch,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
`ifdef FIR_ARB_WDOG_EN
  localparam logic [1:0] FLUSH = 2'd2;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

  // The channel index must cover exactly NCH banks of the FIR.
  if (NCH != 2**CW || TIMEOUT < 2) begin : g_cfg_check
    $error("fir_channel_arbiter: NCH must equal 2**CW and TIMEOUT must be >= 2");
  end

  logic [1:0]    state;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] next_ch;
  logic [CW-1:0] scan_idx;
  logic          any_valid;
  logic          accept;
  logic [DW-1:0] s_data [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      s_data[i] = s_tdata[i*DW +: DW];
    end
  end

  // Descending loop so the nearest channel after rr_ptr wins; rr_ptr itself is checked last.
  always_comb begin
    next_ch   = rr_ptr;
    any_valid = 1'b0;
    scan_idx  = rr_ptr;
    for (int i = NCH; i >= 1; i--) begin
      scan_idx = rr_ptr + CW'(i);
      if (s_tvalid[scan_idx]) begin
        next_ch   = scan_idx;
        any_valid = 1'b1;
      end
    end
  end

  assign accept = (state == GRANT) && s_tvalid[grant_ch] && f_s_tready;
  assign busy   = (state != IDLE);

  always_comb begin
    s_tready   = '0;
    f_s_tvalid = 1'b0;
    f_s_tdata  = '0;
    f_s_tlast  = 1'b0;
    f_s_tuser  = '0;
    case (state)
      GRANT: begin
        s_tready[grant_ch] = f_s_tready;
        f_s_tvalid         = s_tvalid[grant_ch];
        f_s_tdata          = s_data[grant_ch];
        f_s_tlast          = s_tlast[grant_ch];
        f_s_tuser          = grant_ch;
      end
`ifdef FIR_ARB_WDOG_EN
      FLUSH: begin
        f_s_tvalid = 1'b1;
        f_s_tlast  = 1'b1;
        f_s_tuser  = grant_ch;
      end
`endif
      default: ;
    endcase
  end

`ifdef FIR_ARB_WDOG_EN
  logic [CNTW-1:0] stall_cnt;
  logic            stall_expired;

  assign stall_expired = !accept && (stall_cnt == CNTW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != GRANT || accept) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
      timeout_err <= (state == FLUSH) && f_s_tready;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= CW'(NCH - 1);
      grant_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_ch <= next_ch;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (accept && s_tlast[grant_ch]) begin
            state  <= IDLE;
            rr_ptr <= grant_ch;
          end
`ifdef FIR_ARB_WDOG_EN
          else if (stall_expired) begin
            state <= FLUSH;
          end
`endif
        end
`ifdef FIR_ARB_WDOG_EN
        FLUSH: begin
          if (f_s_tready) begin
            state  <= IDLE;
            rr_ptr <= grant_ch;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Output demux is stateless; a stalled consumer backpressures the shared FIR.
  assign m_tdata    = f_m_tdata;
  assign m_tlast    = f_m_tlast;
  assign f_m_tready = m_tready[f_m_tuser];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      m_tvalid[i] = f_m_tvalid && (f_m_tuser == CW'(i));
    end
  end

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Directed self-checking bench for fir_channel_arbiter (default build, watchdog disabled).
module tb_fir_channel_arbiter;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int DW  = 24;
  localparam int FL  = 10;

  logic              clk;
  logic              rstn;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [NCH-1:0]    s_tlast;
  logic [DW-1:0]     f_s_tdata;
  logic              f_s_tvalid;
  logic              f_s_tready;
  logic [CW-1:0]     f_s_tuser;
  logic              f_s_tlast;
  logic [DW-1:0]     f_m_tdata;
  logic              f_m_tvalid;
  logic              f_m_tready;
  logic [CW-1:0]     f_m_tuser;
  logic              f_m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [NCH-1:0]    m_tvalid;
  logic [NCH-1:0]    m_tready;
  logic              m_tlast;
  logic [CW-1:0]     grant_ch;
  logic              busy;
  logic              timeout_err;

  fir_channel_arbiter #(.NCH(NCH), .CW(CW), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .f_s_tdata(f_s_tdata), .f_s_tvalid(f_s_tvalid), .f_s_tready(f_s_tready),
    .f_s_tuser(f_s_tuser), .f_s_tlast(f_s_tlast),
    .f_m_tdata(f_m_tdata), .f_m_tvalid(f_m_tvalid), .f_m_tready(f_m_tready),
    .f_m_tuser(f_m_tuser), .f_m_tlast(f_m_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .grant_ch(grant_ch), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beat_cnt[NCH];
  int frames_left[NCH];
  int fir_seen[NCH];
  int cyc;
  bit rand_rdy;
  bit in_frame;
  int cur_ch;
  int frame_q[$];
  int acc_cyc_q[$];
  int last_q[$];

  // Source model: channel i sends i*4096 + beat index, tlast every FL beats.
  task automatic drive_sources();
    for (int i = 0; i < NCH; i++) begin
      s_tvalid[i]            = (frames_left[i] > 0);
      s_tdata[i*DW +: DW]    = DW'(i * 4096 + beat_cnt[i]);
      s_tlast[i]             = ((beat_cnt[i] % FL) == FL - 1);
    end
  endtask

  function automatic int pending();
    int sum = 0;
    for (int i = 0; i < NCH; i++) sum += frames_left[i];
    return sum;
  endfunction

  task automatic step();
    logic [NCH-1:0] hs;
    logic [NCH-1:0] allowed;
    logic [NCH-1:0] one_hot;
    logic [DW-1:0]  exp_d;
    logic           exp_last;
    int             ch;
    @(negedge clk);
    allowed = '0;
    if (busy) allowed[grant_ch] = 1'b1;
    checks++;
    if ((s_tready & ~allowed) !== '0) begin
      errors++;
      $display("[TB] FAIL s_tready_excl: got %b expected only within %b", s_tready, allowed);
    end
    hs = s_tvalid & s_tready;
    if (f_s_tvalid && f_s_tready) begin
      ch       = int'(f_s_tuser);
      exp_d    = DW'(ch * 4096 + fir_seen[ch]);
      exp_last = ((fir_seen[ch] % FL) == FL - 1);
      one_hot  = '0;
      one_hot[ch] = 1'b1;
      checks++;
      if (hs !== one_hot) begin
        errors++;
        $display("[TB] FAIL src_handshake: got %b expected %b", hs, one_hot);
      end
      checks++;
      if (f_s_tdata !== exp_d) begin
        errors++;
        $display("[TB] FAIL fir_tdata ch%0d: got %0h expected %0h", ch, f_s_tdata, exp_d);
      end
      checks++;
      if (f_s_tlast !== exp_last) begin
        errors++;
        $display("[TB] FAIL fir_tlast ch%0d: got %b expected %b", ch, f_s_tlast, exp_last);
      end
      if (in_frame) begin
        checks++;
        if (ch != cur_ch) begin
          errors++;
          $display("[TB] FAIL interleave: got ch%0d expected ch%0d", ch, cur_ch);
        end
      end else begin
        frame_q.push_back(ch);
        cur_ch   = ch;
        in_frame = 1'b1;
      end
      if (f_s_tlast) in_frame = 1'b0;
      fir_seen[ch]++;
      acc_cyc_q.push_back(cyc);
      last_q.push_back(int'(f_s_tlast));
    end else begin
      checks++;
      if (hs !== '0) begin
        errors++;
        $display("[TB] FAIL src_without_fir: got %b expected 0", hs);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (hs[i]) begin
        if (s_tlast[i]) frames_left[i]--;
        beat_cnt[i]++;
      end
    end
    drive_sources();
    f_s_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_frames(input int max_cycles);
    int n = 0;
    while (pending() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("[TB] FAIL run_timeout: got %0d frames pending expected 0", pending());
    end
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    rand_rdy = 1'b0;
    in_frame = 1'b0;
    cyc      = 0;
    for (int i = 0; i < NCH; i++) begin
      beat_cnt[i]    = 0;
      frames_left[i] = 0;
      fir_seen[i]    = 0;
    end
    frame_q.delete();
    acc_cyc_q.delete();
    last_q.delete();
    drive_sources();
    f_s_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    frames_left[2] = 1;
    drive_sources();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checks++;
    if ({busy, grant_ch, s_tready, f_s_tvalid, f_s_tlast, f_s_tuser, timeout_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got busy=%b grant=%0d rdy=%b fv=%b fl=%b fu=%0d te=%b expected all 0",
               busy, grant_ch, s_tready, f_s_tvalid, f_s_tlast, f_s_tuser, timeout_err);
    end
    checks++;
    if (f_s_tdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_tdata: got %0h expected 0", f_s_tdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || grant_ch !== 2'd2) begin
      errors++;
      $display("[TB] FAIL first_arb: got busy=%b grant=%0d expected busy=1 grant=2", busy, grant_ch);
    end
    run_frames(50);
  endtask

  task automatic test_single_channel();
    do_reset();
    frames_left[1] = 2;
    drive_sources();
    run_frames(100);
    checks++;
    if (acc_cyc_q.size() != 20 || frame_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL single_counts: got beats=%0d frames=%0d expected 20 and 2", acc_cyc_q.size(), frame_q.size());
    end else begin
      checks++;
      if (frame_q[0] != 1 || frame_q[1] != 1) begin
        errors++;
        $display("[TB] FAIL single_tuser: got %0d,%0d expected 1,1", frame_q[0], frame_q[1]);
      end
      checks++;
      if (last_q[9] != 1 || last_q[19] != 1 || last_q[8] != 0 || last_q[10] != 0) begin
        errors++;
        $display("[TB] FAIL single_tlast_pos: got b9=%0d b19=%0d b8=%0d b10=%0d expected 1,1,0,0",
                 last_q[9], last_q[19], last_q[8], last_q[10]);
      end
      checks++;
      if (acc_cyc_q[10] - acc_cyc_q[9] != 2 || acc_cyc_q[9] - acc_cyc_q[0] != 9) begin
        errors++;
        $display("[TB] FAIL single_bubble: got gap=%0d span=%0d expected 2 and 9",
                 acc_cyc_q[10] - acc_cyc_q[9], acc_cyc_q[9] - acc_cyc_q[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < NCH; i++) frames_left[i] = 2;
    drive_sources();
    run_frames(200);
    checks++;
    if (frame_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL rr_frames: got %0d expected 8", frame_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (frame_q[k] != exp_order[k]) begin
          errors++;
          $display("[TB] FAIL rr_order[%0d]: got ch%0d expected ch%0d", k, frame_q[k], exp_order[k]);
        end
        checks++;
        if (acc_cyc_q[k*FL + FL - 1] - acc_cyc_q[k*FL] != FL - 1) begin
          errors++;
          $display("[TB] FAIL rr_contig[%0d]: got span %0d expected %0d",
                   k, acc_cyc_q[k*FL + FL - 1] - acc_cyc_q[k*FL], FL - 1);
        end
      end
    end
  endtask

  task automatic test_random_backpressure();
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < NCH; i++) frames_left[i] = 2;
    drive_sources();
    run_frames(2000);
    rand_rdy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (fir_seen[i] != 2 * FL) begin
        errors++;
        $display("[TB] FAIL bp_count ch%0d: got %0d expected %0d", i, fir_seen[i], 2 * FL);
      end
    end
  endtask

  task automatic test_demux();
    logic [3:0] vec_valid  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] vec_user   [5] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [3:0] vec_ready  [5] = '{4'b1011, 4'b1111, 4'b1111, 4'b0001, 4'b0111};
    logic [3:0] exp_mvalid [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b1000};
    logic       exp_fready [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      f_m_tvalid = vec_valid[k][0];
      f_m_tuser  = vec_user[k];
      m_tready   = vec_ready[k];
      f_m_tdata  = DW'(24'h5A0000 + k);
      f_m_tlast  = k[0];
      #1;
      checks++;
      if (m_tvalid !== exp_mvalid[k] || f_m_tready !== exp_fready[k]) begin
        errors++;
        $display("[TB] FAIL demux[%0d]: got mvalid=%b fready=%b expected mvalid=%b fready=%b",
                 k, m_tvalid, f_m_tready, exp_mvalid[k], exp_fready[k]);
      end
      checks++;
      if (m_tdata !== DW'(24'h5A0000 + k) || m_tlast !== k[0]) begin
        errors++;
        $display("[TB] FAIL demux_data[%0d]: got %0h/%b expected %0h/%b",
                 k, m_tdata, m_tlast, 24'h5A0000 + k, k[0]);
      end
    end
    f_m_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    do_reset();
    frames_left[0] = 1;
    drive_sources();
    run_frames(50);
    frames_left[3] = 1;
    drive_sources();
    while (beat_cnt[3] < 5 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (s_tready !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL mid_frame_ready: got %b expected 1000", s_tready);
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (s_tready !== '0 || f_s_tvalid !== 1'b0 || busy !== 1'b0 || grant_ch !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got rdy=%b fv=%b busy=%b grant=%0d expected 0,0,0,0",
               s_tready, f_s_tvalid, busy, grant_ch);
    end
    rstn     = 1'b1;
    in_frame = 1'b0;
    frame_q.delete();
    frames_left[0] = 1;
    drive_sources();
    run_frames(100);
    checks++;
    if (frame_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL post_reset_frames: got %0d expected 2", frame_q.size());
    end else begin
      checks++;
      if (frame_q[0] != 0 || frame_q[1] != 3) begin
        errors++;
        $display("[TB] FAIL post_reset_order: got %0d,%0d expected 0,3", frame_q[0], frame_q[1]);
      end
    end
  endtask

  initial begin
    f_m_tdata  = '0;
    f_m_tvalid = 1'b0;
    f_m_tuser  = '0;
    f_m_tlast  = 1'b0;
    m_tready   = '0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_random_backpressure();
    test_demux();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/fir_channel_arbiter.md
Name: fir_channel_arbiter

Overview:
- Time-shares one lowpass_fir instance among NCH independent 24-bit AXI-Stream sample sources, for example the sonar receive channels.
- Grants the FIR input to one source per frame (tlast-delimited) in round-robin order. Tags each beat with the channel index on tuser, which selects the FIR coefficient/state bank.
- Demultiplexes the FIR output stream back to per-channel outputs by its returned tuser.
- Sits between the channel front-ends and lowpass_fir, and between lowpass_fir and the per-channel consumers.

Parameters:
- NCH, 4, number of source channels; must equal 2**CW.
- CW, 2, channel index width; matches the lowpass_fir tuser width.
- DW, 24, sample width.
- TIMEOUT, 4096, stall cycles before a forced frame close; used only with FIR_ARB_WDOG_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_tdata  in  NCH*DW  source samples; channel i occupies bits [i*DW +: DW].
- s_tvalid  in  NCH  per-channel valid.
- s_tready  out  NCH  per-channel ready.
- s_tlast  in  NCH  per-channel end of frame.
- f_s_tdata  out  DW  to FIR s_axis_tdata.
- f_s_tvalid  out  1  to FIR s_axis_tvalid.
- f_s_tready  in  1  from FIR s_axis_tready.
- f_s_tuser  out  CW  to FIR s_axis_tuser; the granted channel index.
- f_s_tlast  out  1  to FIR s_axis_tlast.
- f_m_tdata  in  DW  from FIR m_axis_tdata.
- f_m_tvalid  in  1  from FIR m_axis_tvalid.
- f_m_tready  out  1  to FIR m_axis_tready.
- f_m_tuser  in  CW  from FIR m_axis_tuser; the destination channel.
- f_m_tlast  in  1  from FIR m_axis_tlast.
- m_tdata  out  DW  filtered sample, shared by all channels.
- m_tvalid  out  NCH  per-channel valid; one-hot or zero.
- m_tready  in  NCH  per-channel ready.
- m_tlast  out  1  filtered end of frame; qualified by m_tvalid.
- grant_ch  out  CW  current or last granted channel.
- busy  out  1  high while in GRANT or FLUSH.
- timeout_err  out  1  one-cycle pulse on a watchdog flush; tied 0 without the macro.

Behaviour:
Reset values:
- state=IDLE; rr_ptr=NCH-1, so ch0 has first priority.
- grant_ch=0, busy=0, timeout_err=0.
- s_tready=0, f_s_tvalid=0, f_s_tlast=0, f_s_tdata=0, f_s_tuser=0.

State machine:
- IDLE:
  - s_tready=0 and f_s_tvalid=0.
  - Scan channels rr_ptr+1, rr_ptr+2, ... modulo NCH; pick the first with s_tvalid=1.
  - Register it into grant_ch and go to GRANT.
  - Arbitration costs exactly one cycle. No valid inputs: remain in IDLE.
- GRANT, with g=grant_ch:
  - Combinational pass-through: f_s_tdata=s_tdata[g], f_s_tvalid=s_tvalid[g], f_s_tlast=s_tlast[g], f_s_tuser=g.
  - s_tready[g]=f_s_tready; all other s_tready bits are 0.
  - s_tready never depends combinationally on any s_tvalid.
  - On an accepted beat with tlast (s_tvalid[g] & f_s_tready & s_tlast[g]): go to IDLE next cycle and set rr_ptr=g.
  - The grant is never revoked mid-frame, except by the watchdog.
- FLUSH: exists only with the macro; see Optional Feature.

Fairness and throughput:
- Fairness is per frame, not per beat. One idle bubble cycle follows every frame.
- A 1-beat frame (tlast on the first beat) is legal: GRANT lasts one accepted beat.

Output demux:
- Purely combinational, zero latency; independent of the input-side state.
- m_tdata=f_m_tdata and m_tlast=f_m_tlast.
- m_tvalid[i]=f_m_tvalid & (f_m_tuser==i).
- f_m_tready=m_tready[f_m_tuser].
- Backpressure from one output channel therefore stalls the shared FIR.

Simultaneous events:
- A new requester appearing during GRANT waits for the frame end.
- A channel that finishes a frame and is still valid gets lower priority than all others on the next scan.

Reset mid-frame:
- All state returns to reset values on the next cycle. The partial frame is not closed.
- lowpass_fir must share the same rstn.

Optional Feature:
Macro FIR_ARB_WDOG_EN.

When defined:
- A stall counter runs in GRANT. It clears on every accepted beat and on entry to GRANT, and increments when no beat is accepted.
- When the counter reaches TIMEOUT-1, go to FLUSH.
- FLUSH:
  - Drive f_s_tvalid=1, f_s_tdata=0, f_s_tlast=1, f_s_tuser=g.
  - All s_tready bits are 0.
  - Hold until f_s_tready=1. Then pulse timeout_err for one cycle, set rr_ptr=g, and go to IDLE.
- The rest of the stalled channel's data is later treated as a new frame.

When undefined:
- No counter and no FLUSH state; timeout_err is a constant 0.
- A stalled source holds the grant indefinitely.

Test Plan:
1. Only ch1 sends two 10-beat frames; FIR always ready -> f_s_tuser=1 on all 20 beats, f_s_tlast on beats 10 and 20, one IDLE cycle between frames, busy=0 afterwards.
2. All four channels continuously valid after reset, 10-beat frames -> grant_ch sequence 0,1,2,3,0,1; each frame contiguous on f_s_*; no interleaving of beats.
3. f_s_tready random 50%, channels loaded with incrementing per-channel data -> per-channel output order is intact; no beat lost or duplicated; s_tready is high only for the granted channel.
4. f_m_tvalid=1, f_m_tuser=2, m_tready=4'b1011 -> m_tvalid=4'b0100, f_m_tready=0; after m_tready[2]=1, the beat transfers in that same cycle.
5. Assert rstn=0 at beat 5 of a ch3 frame -> the next cycle has s_tready=0 and f_s_tvalid=0; after release, with ch0 and ch3 both valid, ch0 is granted first.
6. (FIR_ARB_WDOG_EN, TIMEOUT=16) ch1 drops valid after beat 3 -> 16 cycles later a flush beat with tdata 0, tlast 1, tuser 1 is issued; timeout_err pulses once; the next grant goes to the next valid channel after ch1.
